// File: rtl/frame_sequencer_pkg.sv
// Shared types for the frame sequencer.
//   speed_t     : speed setting at the default width
//   gen_t       : generation counter at the default width
//   seq_state_t : sequencer FSM states
package frame_sequencer_pkg;

  localparam int unsigned DefSpeedW = 4;
  localparam int unsigned DefGenW   = 32;

  typedef logic [DefSpeedW-1:0] speed_t;
  typedef logic [DefGenW-1:0]   gen_t;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StRun,
    StSwap
  } seq_state_t;

endpackage

// File: rtl/frame_sequencer_done_collector.sv
// Joins the renderer and a set of logic engines for one frame.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_load         : start of frame; clears render_seen and loads the pending mask
//   i_load_ones    : with i_load, load pending as all ones (generation launched)
//   i_sample       : done pulses are accepted only while high
//   i_render_done  : renderer done pulse
//   i_logic_done   : per-engine done pulses
//   o_all_done     : every party has reported, counting pulses present this cycle
module frame_sequencer_done_collector #(
  parameter int unsigned NumEngines = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_load,
  input  logic                  i_load_ones,
  input  logic                  i_sample,
  input  logic                  i_render_done,
  input  logic [NumEngines-1:0] i_logic_done,
  output logic                  o_all_done
);

  logic [NumEngines-1:0] r_pending;
  logic [NumEngines-1:0] w_pending_next;
  logic                  r_render_seen;

  always_comb begin
    w_pending_next = r_pending & ~i_logic_done;
    // Include this cycle's pulses so the FSM can leave RUN without an extra cycle.
    o_all_done     = i_sample & (r_render_seen | i_render_done) & (w_pending_next == '0);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pending     <= '0;
      r_render_seen <= 1'b0;
    end else if (i_load) begin
      r_pending     <= i_load_ones ? '1 : '0;
      r_render_seen <= 1'b0;
    end else if (i_sample) begin
      r_pending     <= w_pending_next;
      r_render_seen <= r_render_seen | i_render_done;
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// Frame sequencer: starts a render every frame, launches a logic generation when the
// speed divider or a single-step allows it, and swaps the double buffer once all
// engines and the renderer are done. A watchdog aborts a frame stuck in RUN.
//   clk_in, rst_n_in   : clock, synchronous active-low reset
//   render_done_in     : renderer done pulse
//   logic_done_in      : per-engine done pulses
//   speed_in           : 0 = paused, larger = faster
//   step_in            : single-generation request while paused
//   render_start_out   : render start pulse
//   logic_start_out    : engine start pulse
//   buf_swap_out       : double-buffer swap pulse
//   buf_sel_out        : front buffer index
//   gen_count_out      : completed generations
//   busy_out           : generation in flight
//   timeout_out        : sticky watchdog flag
module frame_sequencer
  import frame_sequencer_pkg::*;
#(
  parameter int unsigned NUM_ENGINES = 1,
  parameter int unsigned SPEED_W     = 4,
  parameter int unsigned TIMEOUT_W   = 24,
  parameter int unsigned GEN_W       = 32
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   render_done_in,
  input  logic [NUM_ENGINES-1:0] logic_done_in,
  input  logic [SPEED_W-1:0]     speed_in,
  input  logic                   step_in,
  output logic                   render_start_out,
  output logic                   logic_start_out,
  output logic                   buf_swap_out,
  output logic                   buf_sel_out,
  output logic [GEN_W-1:0]       gen_count_out,
  output logic                   busy_out,
  output logic                   timeout_out
);

  // RUN cycle index (0-based) on which the watchdog fires: 2^TIMEOUT_W - 1 cycles in RUN.
  localparam logic [TIMEOUT_W-1:0] WdLast = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  seq_state_t           r_state;
  logic [SPEED_W-1:0]   r_frame_cnt;
  logic                 r_step;
  logic [TIMEOUT_W-1:0] r_wd;
  logic                 r_abort;
  logic                 r_render_start;
  logic                 r_logic_start;
  logic                 r_buf_swap;
  logic                 r_buf_sel;
  logic [GEN_W-1:0]     r_gen;
  logic                 r_busy;
  logic                 r_timeout;

  logic                 w_paused;
  logic                 w_gen_due;
  logic                 w_step_next;
  logic [SPEED_W:0]     w_period;
  logic [SPEED_W:0]     w_inc;
  logic [SPEED_W-1:0]   w_frame_cnt_next;
  logic                 w_is_start;
  logic                 w_is_run;
  logic                 w_all_done;

  always_comb begin
    w_paused   = (speed_in == '0);
    w_is_start = (r_state == StStart);
    w_is_run   = (r_state == StRun);
    w_gen_due  = (!w_paused && r_frame_cnt == '0) || (w_paused && r_step);
    // Latch holds only while paused; consumed by START whether or not a new step arrives.
    w_step_next = w_paused && (step_in || (r_step && !w_is_start));
    w_period    = {1'b1, {SPEED_W{1'b0}}} - {1'b0, speed_in};
    w_inc       = {1'b0, r_frame_cnt} + {{SPEED_W{1'b0}}, 1'b1};
    if (w_paused || w_inc >= w_period) begin
      w_frame_cnt_next = '0;
    end else begin
      w_frame_cnt_next = w_inc[SPEED_W-1:0];
    end
  end

  frame_sequencer_done_collector #(
    .NumEngines(NUM_ENGINES)
  ) u_done_collector (
    .i_clk        (clk_in),
    .i_rst_n      (rst_n_in),
    .i_load       (w_is_start),
    .i_load_ones  (w_gen_due),
    .i_sample     (w_is_run),
    .i_render_done(render_done_in),
    .i_logic_done (logic_done_in),
    .o_all_done   (w_all_done)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state        <= StIdle;
      r_frame_cnt    <= '0;
      r_step         <= 1'b0;
      r_wd           <= '0;
      r_abort        <= 1'b0;
      r_render_start <= 1'b0;
      r_logic_start  <= 1'b0;
      r_buf_swap     <= 1'b0;
      r_buf_sel      <= 1'b0;
      r_gen          <= '0;
      r_busy         <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      r_render_start <= 1'b0;
      r_logic_start  <= 1'b0;
      r_buf_swap     <= 1'b0;
      r_step         <= w_step_next;
      unique case (r_state)
        StIdle: r_state <= StStart;
        StStart: begin
          r_render_start <= 1'b1;
          r_wd           <= '0;
          r_abort        <= 1'b0;
          if (w_gen_due) begin
            r_logic_start <= 1'b1;
            r_busy        <= 1'b1;
          end
          r_state <= StRun;
        end
        StRun: begin
          r_wd <= r_wd + TIMEOUT_W'(1);
          // Normal completion wins over a watchdog expiring on the same cycle.
          if (w_all_done) begin
            r_state <= StSwap;
          end else if (r_wd == WdLast) begin
            r_timeout <= 1'b1;
            r_abort   <= 1'b1;
            r_state   <= StSwap;
          end
        end
        StSwap: begin
          if (r_busy && !r_abort) begin
            r_buf_swap <= 1'b1;
            r_buf_sel  <= ~r_buf_sel;
            r_gen      <= r_gen + GEN_W'(1);
          end
          r_busy      <= 1'b0;
          r_frame_cnt <= w_frame_cnt_next;
          r_state     <= StStart;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign render_start_out = r_render_start;
  assign logic_start_out  = r_logic_start;
  assign buf_swap_out     = r_buf_swap;
  assign buf_sel_out      = r_buf_sel;
  assign gen_count_out    = r_gen;
  assign busy_out         = r_busy;
  assign timeout_out      = r_timeout;

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer: a frame-level model pushes the expected
// outcome of each frame when its stimulus starts; a monitor pops and compares when the
// DUT begins the following frame.
module tb_frame_sequencer;

  localparam int NE       = 4;
  localparam int SW       = 4;
  localparam int TW       = 5;
  localparam int GW       = 32;
  localparam int WdCycles = (1 << TW) - 1;

  typedef struct packed {
    logic        ls;
    logic [31:0] swaps;
    logic        sel;
    logic [31:0] gen;
    logic        tmo;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          render_done = 1'b0;
  logic [NE-1:0] logic_done = '0;
  logic [SW-1:0] speed = '0;
  logic          step = 1'b0;
  logic          render_start, logic_start, buf_swap, buf_sel, busy, timeout;
  logic [GW-1:0] gen_count;

  always #5 clk = ~clk;

  frame_sequencer #(
    .NUM_ENGINES(NE),
    .SPEED_W    (SW),
    .TIMEOUT_W  (TW),
    .GEN_W      (GW)
  ) dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .render_done_in  (render_done),
    .logic_done_in   (logic_done),
    .speed_in        (speed),
    .step_in         (step),
    .render_start_out(render_start),
    .logic_start_out (logic_start),
    .buf_swap_out    (buf_swap),
    .buf_sel_out     (buf_sel),
    .gen_count_out   (gen_count),
    .busy_out        (busy),
    .timeout_out     (timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Frame-level reference model.
  exp_t          exp_q[$];
  int            m_cnt = 0;
  bit            m_step = 1'b0;
  int            m_gen = 0;
  bit            m_sel = 1'b0;
  bit            m_tmo = 1'b0;
  logic [SW-1:0] start_speed = '0;

  // Monitor: frame boundaries are render_start pulses.
  bit   mon_en = 1'b0;
  bit   open_frame = 1'b0;
  bit   obs_ls, obs_busy;
  int   obs_swaps;
  exp_t mon_e;

  always @(negedge clk) begin
    if (mon_en) begin
      if (buf_swap) obs_swaps++;
      if (render_start) begin
        if (open_frame) begin
          if (exp_q.size() == 0) begin
            check_val("sb_empty", 64'd1, 64'd0);
          end else begin
            mon_e = exp_q.pop_front();
            check_val("logic_start", 64'(obs_ls), 64'(mon_e.ls));
            check_val("busy", 64'(obs_busy), 64'(mon_e.ls));
            check_val("swaps", 64'(obs_swaps), 64'(mon_e.swaps));
            check_val("buf_sel", 64'(buf_sel), 64'(mon_e.sel));
            check_val("gen_count", 64'(gen_count), 64'(mon_e.gen));
            check_val("timeout", 64'(timeout), 64'(mon_e.tmo));
          end
        end
        open_frame = 1'b1;
        obs_ls     = logic_start;
        obs_busy   = busy;
        obs_swaps  = 0;
      end
    end
  end

  // Called at the negedge where render_start is seen (first RUN cycle). Delays are in
  // cycles from then; -1 means never.
  task automatic run_frame(input int spd, input int rd, input int d0, input int d1,
                           input int d2, input int d3, input int s0, input int s1);
    bit   ls, abort, was_tmo, fin;
    int   c, len, t, t_tmo;
    int   d[4];
    exp_t e;
    d = '{d0, d1, d2, d3};
    ls = (start_speed != 0 && m_cnt == 0) || (start_speed == 0 && m_step);
    if (start_speed == 0) m_step = 1'b0;
    c = rd + 1;
    abort = 1'b0;
    if (ls) begin
      foreach (d[i]) begin
        if (d[i] < 0) abort = 1'b1;
        else if (d[i] + 1 > c) c = d[i] + 1;
      end
    end
    if (c > WdCycles) abort = 1'b1;
    was_tmo = m_tmo;
    if (abort) m_tmo = 1'b1;
    if (ls && !abort) begin
      m_gen++;
      m_sel = !m_sel;
    end
    len = abort ? WdCycles + 2 : c + 2;
    if (spd == 0) m_cnt = 0;
    else begin
      m_cnt++;
      if (m_cnt >= (1 << SW) - spd) m_cnt = 0;
    end
    e.ls = ls; e.swaps = (ls && !abort) ? 1 : 0; e.sel = m_sel; e.gen = m_gen; e.tmo = m_tmo;
    exp_q.push_back(e);

    speed = SW'(spd);
    if (spd != 0) m_step = 1'b0;
    t = 0; t_tmo = -1; fin = 1'b0;
    while (!fin) begin
      render_done = (t == rd);
      for (int i = 0; i < NE; i++) logic_done[i] = (t == d[i]);
      step = (t == s0) || (t == s1);
      if (step && spd == 0) m_step = 1'b1;
      @(negedge clk);
      t++;
      if (timeout && t_tmo < 0) t_tmo = t;
      if (render_start) fin = 1'b1;
      else if (t >= 200) begin
        check_val("frame_bound", 64'(t), 64'(len));
        fin = 1'b1;
      end
    end
    render_done = 1'b0;
    logic_done  = '0;
    step        = 1'b0;
    check_val("frame_len", 64'(t), 64'(len));
    if (abort && !was_tmo) check_val("timeout_rise", 64'(t_tmo), 64'(WdCycles));
    start_speed = SW'(spd);
  endtask

  initial begin
    int n;
    speed = 4'd15;
    start_speed = 4'd15;
    repeat (3) @(negedge clk);
    check_val("rst_render_start", 64'(render_start), 64'd0);
    check_val("rst_logic_start", 64'(logic_start), 64'd0);
    check_val("rst_buf_swap", 64'(buf_swap), 64'd0);
    check_val("rst_buf_sel", 64'(buf_sel), 64'd0);
    check_val("rst_gen_count", 64'(gen_count), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_timeout", 64'(timeout), 64'd0);

    mon_en = 1'b1;
    rst_n  = 1'b1;
    n = 0;
    while (!render_start && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_val("first_render_start", 64'(n), 64'd2);
    check_val("first_logic_start", 64'(logic_start), 64'd1);

    repeat (3) run_frame(15, 10, 5, 5, 5, 5, -1, -1);
    repeat (9) run_frame(13, 4, 2, 2, 2, 2, -1, -1);
    run_frame(0, 6, 2, 2, 2, 2, 1, 3);     // two steps in one frame
    run_frame(0, 3, 2, 2, 2, 2, -1, -1);   // consumes the step
    run_frame(15, 3, 2, 2, 2, 2, -1, -1);  // paused START, no latch: no generation
    run_frame(15, 10, 3, 7, 7, 20, -1, -1);
    run_frame(15, 25, 3, 3, 3, 3, -1, -1); // render is the last to finish
    run_frame(15, 0, 0, 0, 0, 0, -1, -1);  // minimum-latency frame
    run_frame(15, 5, -1, 2, 2, 2, -1, -1); // engine 0 hangs: watchdog abort
    run_frame(15, 5, 1, 1, 1, 1, -1, -1);  // recovers, timeout stays set

    @(negedge clk);
    mon_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_val("midrst_render_start", 64'(render_start), 64'd0);
    check_val("midrst_logic_start", 64'(logic_start), 64'd0);
    check_val("midrst_buf_sel", 64'(buf_sel), 64'd0);
    check_val("midrst_busy", 64'(busy), 64'd0);
    check_val("midrst_timeout", 64'(timeout), 64'd0);
    for (int i = 0; i < 3; i++) begin
      check_val("midrst_buf_swap", 64'(buf_swap), 64'd0);
      check_val("midrst_gen_count", 64'(gen_count), 64'd0);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
